memory_stage: RTL and testbench

Memory stage of the five-stage Y86-64 pipeline, directly downstream of the execute stage. It holds the M pipeline register, which captures execute outputs at each rising edge. It also contains a byte-addressed, little-endian data memory, performs quad-word reads and writes, and produces the memory-stage status plus the forwarding values for decode and the W register.

---
 rtl/memory_stage.sv | 136 +++++++++++++
 tb/tb_memory_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed little-endian data
// memory with quad-word access, bounds checking and memory-stage status.
module memory_stage #(
  parameter int         DEPTH = 8192,
  parameter logic [2:0] SAOK  = 3'b001,
  parameter logic [2:0] SHLT  = 3'b010,
  parameter logic [2:0] SADR  = 3'b011,
  parameter logic [2:0] SINS  = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_bubble,
  input  logic [2:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [2:0]  W_stat,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH - 8);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  if (DEPTH < 8) begin : g_bad_depth
    $error("memory_stage: DEPTH must be at least 8");
  end
  if (SAOK == SHLT || SAOK == SADR || SAOK == SINS ||
      SHLT == SADR || SHLT == SINS || SADR == SINS) begin : g_bad_stat
    $error("memory_stage: status codes must be distinct");
  end

  logic [2:0]    r_stat;
  logic [3:0]    r_icode;
  logic          r_cnd;
  logic [63:0]   r_valE;
  logic [63:0]   r_valA;
  logic [3:0]    r_dstE;
  logic [3:0]    r_dstM;
  logic [7:0]    r_mem [DEPTH];

  logic          w_read;
  logic          w_write;
  logic [63:0]   w_addr;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_store;

  // M pipeline register: a bubble on reset or request, otherwise capture E
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      r_stat  <= SAOK;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= R_NONE;
      r_dstM  <= R_NONE;
    end else begin
      r_stat  <= E_stat;
      r_icode <= E_icode;
      r_cnd   <= e_cnd;
      r_valE  <= e_valE;
      r_valA  <= e_valA;
      r_dstE  <= e_dstE;
      r_dstM  <= E_dstM;
    end
  end

  always_comb begin
    w_read  = 1'b0;
    w_write = 1'b0;
    w_addr  = r_valE;
    unique case (r_icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: w_write = 1'b1;
      I_MRMOVQ:                  w_read  = 1'b1;
      I_RET, I_POPQ: begin
        w_read = 1'b1;
        w_addr = r_valA;
      end
      default: ;
    endcase
  end

  // Compare against DEPTH-8 rather than computing addr+7 so that addresses
  // near 2^64 cannot wrap into range.
  assign w_err   = (w_read || w_write) && (w_addr > LIMIT);
  assign w_idx   = w_addr[AW-1:0];
  assign w_store = w_write && !w_err && (r_stat == SAOK) && (W_stat == SAOK) && !rst;

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_idx + AW'(i)] <= r_valA[8*i +: 8];
      end
    end
  end

  always_comb begin
    m_valM = '0;
    if (w_read && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = r_mem[w_idx + AW'(i)];
      end
    end
  end

  assign m_stat  = w_err ? SADR : r_stat;
  assign M_stat  = r_stat;
  assign M_icode = r_icode;
  assign M_cnd   = r_cnd;
  assign M_valE  = r_valE;
  assign M_valA  = r_valA;
  assign M_dstE  = r_dstE;
  assign M_dstM  = r_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model with a sparse byte memory.
module tb_memory_stage;

  localparam longint unsigned D = 8192;
  localparam logic [2:0] SAOK = 3'b001, SHLT = 3'b010, SADR = 3'b011, SINS = 3'b100;

  logic        clk = 1'b0;
  logic        rst, M_bubble, e_cnd;
  logic [2:0]  E_stat, W_stat;
  logic [3:0]  E_icode, e_dstE, E_dstM;
  logic [63:0] e_valE, e_valA;
  logic [2:0]  M_stat, m_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA, m_valM;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_stage #(.DEPTH(8192)) dut (
    .clk(clk), .rst(rst), .M_bubble(M_bubble), .E_stat(E_stat), .E_icode(E_icode),
    .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
    .W_stat(W_stat), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat)
  );

  // Behavioural model: the instruction currently in M plus a sparse memory.
  logic [2:0]  q_stat = SAOK;
  logic [3:0]  q_ic = 4'h1, q_dE = 4'hF, q_dM = 4'hF;
  logic        q_cnd = 1'b0;
  logic [63:0] q_vE = '0, q_vA = '0;
  logic [7:0]  mm [longint unsigned];
  bit          armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_rd(input logic [3:0] ic);
    return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
  endfunction
  function automatic bit is_wr(input logic [3:0] ic);
    return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
  endfunction
  function automatic logic [63:0] addr_of(input logic [3:0] ic, input logic [63:0] vE, vA);
    return (ic == 4'h9 || ic == 4'hB) ? vA : vE;
  endfunction
  function automatic bit fault(input logic [3:0] ic, input logic [63:0] vE, vA);
    return (is_rd(ic) || is_wr(ic)) && (addr_of(ic, vE, vA) > D - 8);
  endfunction
  function automatic logic [63:0] mread(input longint unsigned a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (mm.exists(a + i)) r[8*i +: 8] = mm[a + i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst && is_wr(q_ic) && !fault(q_ic, q_vE, q_vA) && q_stat == SAOK && W_stat == SAOK)
      for (int i = 0; i < 8; i++) mm[addr_of(q_ic, q_vE, q_vA) + i] = q_vA[8*i +: 8];
    if (rst || M_bubble) begin
      q_stat = SAOK; q_ic = 4'h1; q_cnd = 1'b0; q_vE = '0; q_vA = '0; q_dE = 4'hF; q_dM = 4'hF;
    end else begin
      q_stat = E_stat; q_ic = E_icode; q_cnd = e_cnd; q_vE = e_valE; q_vA = e_valA;
      q_dE = e_dstE; q_dM = E_dstM;
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("M_stat", 64'(M_stat), 64'(q_stat));
      chk("M_icode", 64'(M_icode), 64'(q_ic));
      chk("M_cnd", 64'(M_cnd), 64'(q_cnd));
      chk("M_valE", M_valE, q_vE);
      chk("M_valA", M_valA, q_vA);
      chk("M_dstE", 64'(M_dstE), 64'(q_dE));
      chk("M_dstM", 64'(M_dstM), 64'(q_dM));
      chk("m_stat", 64'(m_stat), fault(q_ic, q_vE, q_vA) ? 64'(SADR) : 64'(q_stat));
      chk("m_valM", m_valM, (is_rd(q_ic) && !fault(q_ic, q_vE, q_vA))
                            ? mread(addr_of(q_ic, q_vE, q_vA)) : 64'h0);
    end
  end

  task automatic issue(input logic [3:0] ic, input logic [63:0] vE, input logic [63:0] vA,
                       input logic [2:0] st, input logic [2:0] ws, input bit bub, input bit r);
    E_icode = ic; e_valE = vE; e_valA = vA; E_stat = st; W_stat = ws;
    M_bubble = bub; rst = r;
    e_cnd = 1'($urandom); e_dstE = 4'($urandom); E_dstM = 4'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_addr();
    int sel = $urandom_range(0, 7);
    if (sel <= 5) return 64'($urandom_range(0, int'(D) + 8));
    if (sel == 6) return D - 12 + 64'($urandom_range(0, 12));
    return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1; M_bubble = 1'b0; W_stat = SAOK; E_stat = SAOK; E_icode = 4'h4;
    e_cnd = 1'b0; e_valE = '0; e_valA = '0; e_dstE = '0; E_dstM = '0;

    // reset with random E-side inputs
    for (int i = 0; i < 2; i++)
      issue(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), SAOK, 1'b0, 1'b1);
    chk("rst_icode", 64'(M_icode), 64'h1);
    chk("rst_dstE", 64'(M_dstE), 64'hF);
    chk("rst_dstM", 64'(M_dstM), 64'hF);
    chk("rst_Mstat", 64'(M_stat), 64'(SAOK));
    chk("rst_mstat", 64'(m_stat), 64'(SAOK));
    chk("rst_valM", m_valM, 64'h0);

    // store then load
    issue(4'h4, 64'h100, 64'h1122334455667788, SAOK, SAOK, 1'b0, 1'b0);
    issue(4'h5, 64'h100, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("st_ld_valM", m_valM, 64'h1122334455667788);
    chk("model_mem100", 64'(mm[64'h100]), 64'h88);
    chk("model_mem107", 64'(mm[64'h107]), 64'h11);

    // stack push/pop at the top of memory
    issue(4'hA, 64'h1FF8, 64'hDEAD, SAOK, SAOK, 1'b0, 1'b0);
    chk("push_stat", 64'(m_stat), 64'(SAOK));
    issue(4'hB, 64'h0, 64'h1FF8, SAOK, SAOK, 1'b0, 1'b0);
    chk("pop_valM", m_valM, 64'hDEAD);
    chk("pop_stat", 64'(m_stat), 64'(SAOK));

    // bounds
    issue(4'h5, D - 8, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("bound_ok_stat", 64'(m_stat), 64'(SAOK));
    chk("bound_ok_valM", m_valM, 64'hDEAD);
    issue(4'h5, D - 7, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("bound_bad_stat", 64'(m_stat), 64'(SADR));
    chk("bound_bad_valM", m_valM, 64'h0);
    issue(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555, SAOK, SAOK, 1'b0, 1'b0);
    chk("wrap_stat", 64'(m_stat), 64'(SADR));

    // store suppression by older fault, then by own fault
    issue(4'h4, 64'h40, '1, SAOK, SHLT, 1'b0, 1'b0);
    issue(4'h5, 64'h40, 64'h0, SAOK, SHLT, 1'b0, 1'b0);
    chk("wstat_suppress", m_valM, 64'h0);
    issue(4'h4, 64'h40, '1, SINS, SAOK, 1'b0, 1'b0);
    chk("sins_stat", 64'(m_stat), 64'(SINS));
    issue(4'h5, 64'h40, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("sins_suppress", m_valM, 64'h0);

    // bubble over a valid store
    issue(4'h4, 64'h40, '1, SAOK, SAOK, 1'b1, 1'b0);
    chk("bubble_icode", 64'(M_icode), 64'h1);
    issue(4'h5, 64'h40, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("bubble_nowrite", m_valM, 64'h0);

    // unaligned round trip, overlapping the earlier store
    issue(4'h4, 64'h103, 64'hA1B2C3D4E5F60718, SAOK, SAOK, 1'b0, 1'b0);
    issue(4'h5, 64'h103, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("unaligned_valM", m_valM, 64'hA1B2C3D4E5F60718);
    issue(4'h5, 64'h100, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("overlap_valM", m_valM, 64'hD4E5F60718667788);

    // reset drops a store sitting in M
    issue(4'h4, 64'h200, 64'hCAFE, SAOK, SAOK, 1'b0, 1'b0);
    issue(4'h5, 64'h200, 64'h0, SAOK, SAOK, 1'b0, 1'b1);
    chk("rst_bubble_icode", 64'(M_icode), 64'h1);
    issue(4'h5, 64'h200, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("rst_drop_store", m_valM, 64'h0);
    issue(4'h4, 64'h200, 64'hCAFE, SAOK, SAOK, 1'b0, 1'b0);
    issue(4'h5, 64'h200, 64'h0, SAOK, SAOK, 1'b0, 1'b0);
    chk("store_after_rst", m_valM, 64'hCAFE);

    // randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 500; n++) begin
      logic [2:0] st, ws;
      st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : SAOK;
      ws = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : SAOK;
      issue(4'($urandom), rnd_addr(), ($urandom_range(0, 1) == 0) ? rnd_addr() : {$urandom, $urandom},
            st, ws, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
